// File: rtl/issue_queue.sv
// issue_queue: dual-issue circular instruction buffer between decode and execute.
//
// Accepts up to two decoded instructions per cycle, holds them in a DEPTH-entry
// circular FIFO, and issues zero, one or two of the oldest entries per cycle.
// Whether an entry can issue depends on hazards, register dependencies and pairing rules.
//
// Ports
//   i_clk, i_reset      clock, synchronous active-high reset
//   i_flush             drop every entry (mispredict / exception)
//   i_in_valid          decode slot valid, bit 0 is the older slot
//   i_in_payload        per-slot opaque payload, slot i at [i*PW +: PW]
//   i_in_ra1/ra2/rdst   per-slot 5-bit register numbers, slot i at [i*5 +: 5]
//   i_in_regwrite/mem/branch  per-slot flags
//   o_in_ready          decode may push this cycle (room for two)
//   o_head_ra1/ra2      source registers of the two head entries (bypass lookup)
//   i_hazard            head entry i waits on a non-bypassable producer
//   i_ex_ready          execute register accepts this cycle
//   o_out_valid         head entry i issues this cycle
//   o_out_payload       payload of the two head entries
//   o_count             occupied entries
module issue_queue #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned PW    = 64
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_flush,
    input  logic [1:0]               i_in_valid,
    input  logic [2*PW-1:0]          i_in_payload,
    input  logic [9:0]               i_in_ra1,
    input  logic [9:0]               i_in_ra2,
    input  logic [9:0]               i_in_rdst,
    input  logic [1:0]               i_in_regwrite,
    input  logic [1:0]               i_in_mem,
    input  logic [1:0]               i_in_branch,
    output logic                     o_in_ready,
    output logic [9:0]               o_head_ra1,
    output logic [9:0]               o_head_ra2,
    input  logic [1:0]               i_hazard,
    input  logic                     i_ex_ready,
    output logic [1:0]               o_out_valid,
    output logic [2*PW-1:0]          o_out_payload,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    // Entry storage (not reset)
    logic [PW-1:0]    r_payload [DEPTH];
    logic [4:0]       r_ra1     [DEPTH];
    logic [4:0]       r_ra2     [DEPTH];
    logic [4:0]       r_rdst    [DEPTH];
    logic [DEPTH-1:0] r_regwrite;
    logic [DEPTH-1:0] r_mem;
    logic [DEPTH-1:0] r_branch;

    logic [AW-1:0] r_head;
    logic [AW-1:0] r_tail;
    logic [CW-1:0] r_count;

    logic [AW-1:0] w_h0;
    logic [AW-1:0] w_h1;
    logic          w_v0;
    logic          w_v1;
    logic          w_dep;
    logic          w_issue0;
    logic          w_issue1;
    logic          w_in_ready;
    logic [1:0]    w_push;
    logic [1:0]    w_enq;
    logic [1:0]    w_deq;
    logic [AW-1:0] w_wr1_idx;

    assign w_h0 = r_head;
    assign w_h1 = r_head + AW'(1);
    assign w_v0 = (r_count != '0);
    assign w_v1 = (r_count >= CW'(2));

    // An older writer of r0 never creates a dependency
    assign w_dep = r_regwrite[w_h0] & (r_rdst[w_h0] != 5'd0) &
                   ((r_ra1[w_h1] == r_rdst[w_h0]) | (r_ra2[w_h1] == r_rdst[w_h0]));

    assign w_issue0 = w_v0 & i_ex_ready & ~i_hazard[0] & ~i_flush;
    assign w_issue1 = w_issue0 & w_v1 & ~i_hazard[1] & ~w_dep &
                      ~(r_mem[w_h0] & r_mem[w_h1]) & ~r_branch[w_h1];

    // Room for two is judged on the registered count only; same-cycle issue gives no credit
    assign w_in_ready = (r_count <= CW'(DEPTH - 2));
    assign w_push     = i_in_valid & {2{w_in_ready}};
    assign w_enq      = {1'b0, w_push[0]} + {1'b0, w_push[1]};
    assign w_deq      = {1'b0, w_issue0} + {1'b0, w_issue1};

    // Slot 1 lands directly at tail when slot 0 is empty (compaction)
    assign w_wr1_idx = r_tail + AW'(w_push[0]);

    always_ff @(posedge i_clk) begin
        if (!i_reset && !i_flush) begin
            if (w_push[0]) begin
                r_payload[r_tail]  <= i_in_payload[0 +: PW];
                r_ra1[r_tail]      <= i_in_ra1[0 +: 5];
                r_ra2[r_tail]      <= i_in_ra2[0 +: 5];
                r_rdst[r_tail]     <= i_in_rdst[0 +: 5];
                r_regwrite[r_tail] <= i_in_regwrite[0];
                r_mem[r_tail]      <= i_in_mem[0];
                r_branch[r_tail]   <= i_in_branch[0];
            end
            if (w_push[1]) begin
                r_payload[w_wr1_idx]  <= i_in_payload[PW +: PW];
                r_ra1[w_wr1_idx]      <= i_in_ra1[5 +: 5];
                r_ra2[w_wr1_idx]      <= i_in_ra2[5 +: 5];
                r_rdst[w_wr1_idx]     <= i_in_rdst[5 +: 5];
                r_regwrite[w_wr1_idx] <= i_in_regwrite[1];
                r_mem[w_wr1_idx]      <= i_in_mem[1];
                r_branch[w_wr1_idx]   <= i_in_branch[1];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset || i_flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_head  <= r_head + AW'(w_deq);
            r_tail  <= r_tail + AW'(w_enq);
            r_count <= r_count + CW'(w_enq) - CW'(w_deq);
        end
    end

    assign o_in_ready    = w_in_ready;
    assign o_head_ra1    = {r_ra1[w_h1], r_ra1[w_h0]};
    assign o_head_ra2    = {r_ra2[w_h1], r_ra2[w_h0]};
    assign o_out_valid   = {w_issue1, w_issue0};
    assign o_out_payload = {r_payload[w_h1], r_payload[w_h0]};
    assign o_count       = r_count;

endmodule
